// File: rtl/line_cmd_source.sv
// Pen-command front end for line_drawer: queues MOVE/DRAW/CLOSE commands and
// expands them into two-endpoint line transactions held until accepted.
module line_cmd_source #(
  parameter int DEPTH = 4,
  parameter int XW    = 10,
  parameter int YW    = 10,
  parameter int CW    = 12
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     wr_en,
  input  logic [1:0]               wr_cmd,
  input  logic [XW-1:0]            wr_x,
  input  logic [YW-1:0]            wr_y,
  input  logic [CW-1:0]            wr_color,
  output logic                     wr_full,
  output logic [$clog2(DEPTH):0]   wr_count,
  output logic                     wr_overflow,
  output logic [XW-1:0]            x1_out,
  output logic [YW-1:0]            y1_out,
  output logic [XW-1:0]            x2_out,
  output logic [YW-1:0]            y2_out,
  output logic [CW-1:0]            color_out,
  output logic                     out_rts,
  input  logic                     out_rtr,
  output logic                     busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  typedef enum logic [1:0] {
    CMD_MOVE  = 2'b00,
    CMD_DRAW  = 2'b01,
    CMD_CLOSE = 2'b10,
    CMD_NOP   = 2'b11
  } cmd_e;

  logic [1:0]      r_mem_cmd [DEPTH];
  logic [XW-1:0]   r_mem_x   [DEPTH];
  logic [YW-1:0]   r_mem_y   [DEPTH];
  logic [CW-1:0]   r_mem_c   [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_overflow;

  logic [XW-1:0]   r_px, r_sx, r_x1, r_x2;
  logic [YW-1:0]   r_py, r_sy, r_y1, r_y2;
  logic [CW-1:0]   r_color;
  logic            r_rts;

  logic [XW-1:0]   w_px_n, w_sx_n, w_x1_n, w_x2_n;
  logic [YW-1:0]   w_py_n, w_sy_n, w_y1_n, w_y2_n;
  logic [CW-1:0]   w_color_n;
  logic            w_rts_n;

  logic            w_full, w_push, w_pop, w_slot_free;
  cmd_e            w_head_cmd;
  logic [XW-1:0]   w_head_x;
  logic [YW-1:0]   w_head_y;
  logic [CW-1:0]   w_head_c;

  // Handshake: a line transfers on an edge where out_rts=1 and out_rtr=1; out_rts
  // is purely registered, and the slot only reloads when empty or transferring.
  assign w_full      = (r_count == CNTW'(DEPTH));
  assign w_push      = wr_en & ~w_full;
  assign w_slot_free = ~r_rts | out_rtr;
  assign w_pop       = (r_count != '0) & w_slot_free;

  assign w_head_cmd  = cmd_e'(r_mem_cmd[r_rd_ptr]);
  assign w_head_x    = r_mem_x[r_rd_ptr];
  assign w_head_y    = r_mem_y[r_rd_ptr];
  assign w_head_c    = r_mem_c[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_cmd[r_wr_ptr] <= wr_cmd;
      r_mem_x[r_wr_ptr]   <= wr_x;
      r_mem_y[r_wr_ptr]   <= wr_y;
      r_mem_c[r_wr_ptr]   <= wr_color;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNTW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNTW'(1);
      if (wr_en && w_full) r_overflow <= 1'b1;
    end
  end

  // Default keeps the slot loaded only while it is waiting for acceptance.
  always_comb begin
    w_px_n    = r_px;
    w_py_n    = r_py;
    w_sx_n    = r_sx;
    w_sy_n    = r_sy;
    w_x1_n    = r_x1;
    w_y1_n    = r_y1;
    w_x2_n    = r_x2;
    w_y2_n    = r_y2;
    w_color_n = r_color;
    w_rts_n   = r_rts & ~out_rtr;
    if (w_pop) begin
      case (w_head_cmd)
        CMD_MOVE: begin
          w_px_n = w_head_x;
          w_py_n = w_head_y;
          w_sx_n = w_head_x;
          w_sy_n = w_head_y;
        end
        CMD_DRAW: begin
          w_x1_n    = r_px;
          w_y1_n    = r_py;
          w_x2_n    = w_head_x;
          w_y2_n    = w_head_y;
          w_color_n = w_head_c;
          w_rts_n   = 1'b1;
          w_px_n    = w_head_x;
          w_py_n    = w_head_y;
        end
        CMD_CLOSE: begin
          w_x1_n    = r_px;
          w_y1_n    = r_py;
          w_x2_n    = r_sx;
          w_y2_n    = r_sy;
          w_color_n = w_head_c;
          w_rts_n   = 1'b1;
          w_px_n    = r_sx;
          w_py_n    = r_sy;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_px    <= '0;
      r_py    <= '0;
      r_sx    <= '0;
      r_sy    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_x2    <= '0;
      r_y2    <= '0;
      r_color <= '0;
      r_rts   <= 1'b0;
    end else begin
      r_px    <= w_px_n;
      r_py    <= w_py_n;
      r_sx    <= w_sx_n;
      r_sy    <= w_sy_n;
      r_x1    <= w_x1_n;
      r_y1    <= w_y1_n;
      r_x2    <= w_x2_n;
      r_y2    <= w_y2_n;
      r_color <= w_color_n;
      r_rts   <= w_rts_n;
    end
  end

  assign wr_full     = w_full;
  assign wr_count    = r_count;
  assign wr_overflow = r_overflow;
  assign x1_out      = r_x1;
  assign y1_out      = r_y1;
  assign x2_out      = r_x2;
  assign y2_out      = r_y2;
  assign color_out   = r_color;
  assign out_rts     = r_rts;
  assign busy        = (r_count != '0) | r_rts;

endmodule

// File: tb/tb_line_cmd_source.sv
// Bench for line_cmd_source: hand-derived vector table, directed corner
// sequences and a queue-based reference model run under random stimulus.
module tb_line_cmd_source;

  localparam int DEPTH = 4;
  localparam int XW    = 10;
  localparam int YW    = 10;
  localparam int CW    = 12;

  localparam logic [1:0] MOVE  = 2'b00;
  localparam logic [1:0] DRAW  = 2'b01;
  localparam logic [1:0] CLOSE = 2'b10;
  localparam logic [1:0] NOP   = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  logic                   wr_en;
  logic [1:0]             wr_cmd;
  logic [XW-1:0]          wr_x;
  logic [YW-1:0]          wr_y;
  logic [CW-1:0]          wr_color;
  logic                   wr_full;
  logic [$clog2(DEPTH):0] wr_count;
  logic                   wr_overflow;
  logic [XW-1:0]          x1_out, x2_out;
  logic [YW-1:0]          y1_out, y2_out;
  logic [CW-1:0]          color_out;
  logic                   out_rts;
  logic                   out_rtr;
  logic                   busy;

  line_cmd_source #(.DEPTH(DEPTH), .XW(XW), .YW(YW), .CW(CW)) dut (
    .clk(clk), .rst_(rst_),
    .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .wr_full(wr_full), .wr_count(wr_count), .wr_overflow(wr_overflow),
    .x1_out(x1_out), .y1_out(y1_out), .x2_out(x2_out), .y2_out(y2_out),
    .color_out(color_out), .out_rts(out_rts), .out_rtr(out_rtr), .busy(busy)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]    cmd;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
  } ent_t;

  ent_t          m_fifo[$];
  logic [XW-1:0] m_px, m_sx, m_x1, m_x2;
  logic [YW-1:0] m_py, m_sy, m_y1, m_y2;
  logic [CW-1:0] m_c;
  logic          m_rts, m_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XW-1:0] exp_q[$];
  logic [XW-1:0] got_q[$];

  function automatic logic [51:0] ln(input int x1, input int y1, input int x2,
                                     input int y2, input int c);
    return {x1[XW-1:0], y1[YW-1:0], x2[XW-1:0], y2[YW-1:0], c[CW-1:0]};
  endfunction

  function automatic logic [51:0] dut_line();
    return {x1_out, y1_out, x2_out, y2_out, color_out};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_px = '0; m_py = '0; m_sx = '0; m_sy = '0;
    m_x1 = '0; m_y1 = '0; m_x2 = '0; m_y2 = '0; m_c = '0;
    m_rts = 1'b0; m_ovf = 1'b0;
  endtask

  // One clock edge of the pen-command semantics, evaluated on pre-edge state.
  task automatic model_step(input logic en, input logic [1:0] cmd, input logic [XW-1:0] x,
                            input logic [YW-1:0] y, input logic [CW-1:0] c, input logic rtr);
    ent_t e;
    bit full, pop;
    full = (m_fifo.size() == DEPTH);
    pop  = (m_fifo.size() != 0) && (!m_rts || rtr);
    if (m_rts && rtr) m_rts = 1'b0;
    if (pop) begin
      e = m_fifo.pop_front();
      case (e.cmd)
        MOVE: begin m_px = e.x; m_py = e.y; m_sx = e.x; m_sy = e.y; end
        DRAW: begin
          m_x1 = m_px; m_y1 = m_py; m_x2 = e.x; m_y2 = e.y; m_c = e.c; m_rts = 1'b1;
          m_px = e.x; m_py = e.y;
        end
        CLOSE: begin
          m_x1 = m_px; m_y1 = m_py; m_x2 = m_sx; m_y2 = m_sy; m_c = e.c; m_rts = 1'b1;
          m_px = m_sx; m_py = m_sy;
        end
        default: ;
      endcase
    end
    if (en) begin
      if (full) m_ovf = 1'b1;
      else begin
        e.cmd = cmd; e.x = x; e.y = y; e.c = c;
        m_fifo.push_back(e);
      end
    end
  endtask

  task automatic check_model();
    check("rts", out_rts, m_rts);
    check("count", wr_count, m_fifo.size());
    check("full", wr_full, m_fifo.size() == DEPTH);
    check("overflow", wr_overflow, m_ovf);
    check("busy", busy, (m_fifo.size() != 0) || m_rts);
    if (m_rts) check("line", dut_line(), {m_x1, m_y1, m_x2, m_y2, m_c});
  endtask

  task automatic check_reset_values();
    check("rst_rts", out_rts, 0);
    check("rst_count", wr_count, 0);
    check("rst_full", wr_full, 0);
    check("rst_ovf", wr_overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_line", dut_line(), 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic en, input logic [1:0] cmd, input int x, input int y,
                       input int c, input logic rtr);
    wr_en = en; wr_cmd = cmd; wr_x = x[XW-1:0]; wr_y = y[YW-1:0];
    wr_color = c[CW-1:0]; out_rtr = rtr;
    if (out_rts && out_rtr) got_q.push_back(x2_out);
    model_step(en, cmd, x[XW-1:0], y[YW-1:0], c[CW-1:0], rtr);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle(input logic rtr);
    cycle(1'b0, NOP, 0, 0, 0, rtr);
  endtask

  task automatic do_reset();
    wr_en = 0; wr_cmd = NOP; wr_x = '0; wr_y = '0; wr_color = '0; out_rtr = 0;
    rst_ = 1'b0;
    model_reset();
    #2;
    check_reset_values();
    @(posedge clk);
    #1;
    rst_ = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic [1:0] cmd;
    int         x, y, c;
    logic       rtr;
    logic       e_rts;
    logic [51:0] e_line;
    int         e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic [1:0] cmd, input int x, input int y,
                              input int c, input logic e_rts, input logic [51:0] e_line,
                              input int e_cnt);
    vec_t v;
    v.en = en; v.cmd = cmd; v.x = x; v.y = y; v.c = c; v.rtr = 1'b1;
    v.e_rts = e_rts; v.e_line = e_line; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    logic [3:0] pat4;
    logic [4:0] pat5;

    tbl[0]  = mk(1, MOVE,  0,  4, 0,     0, '0, 1);
    tbl[1]  = mk(1, DRAW,  0,  0, 'hF00, 0, '0, 1);
    tbl[2]  = mk(0, NOP,   0,  0, 0,     1, ln(0, 4, 0, 0, 'hF00), 0);
    tbl[3]  = mk(0, NOP,   0,  0, 0,     0, '0, 0);
    tbl[4]  = mk(1, MOVE,  10, 10, 'h0F0, 0, '0, 1);
    tbl[5]  = mk(1, DRAW,  20, 10, 'h0F0, 0, '0, 1);
    tbl[6]  = mk(1, DRAW,  20, 20, 'h0F0, 1, ln(10, 10, 20, 10, 'h0F0), 1);
    tbl[7]  = mk(1, DRAW,  10, 20, 'h0F0, 1, ln(20, 10, 20, 20, 'h0F0), 1);
    tbl[8]  = mk(1, CLOSE, 0,  0, 'h0F0, 1, ln(20, 20, 10, 20, 'h0F0), 1);
    tbl[9]  = mk(0, NOP,   0,  0, 0,     1, ln(10, 20, 10, 10, 'h0F0), 0);
    tbl[10] = mk(0, NOP,   0,  0, 0,     0, '0, 0);
    tbl[11] = mk(1, DRAW,  30, 30, 'h0F0, 0, '0, 1);
    tbl[12] = mk(0, NOP,   0,  0, 0,     1, ln(10, 10, 30, 30, 'h0F0), 0);
    tbl[13] = mk(0, NOP,   0,  0, 0,     0, '0, 0);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].en, tbl[i].cmd, tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].rtr);
      check("tbl_rts", out_rts, tbl[i].e_rts);
      check("tbl_count", wr_count, tbl[i].e_cnt);
      if (tbl[i].e_rts) check("tbl_line", dut_line(), tbl[i].e_line);
    end
    check("single_busy_end", busy, 0);

    // Backpressure: slot must hold while rtr is low, next line follows release.
    do_reset();
    cycle(1, DRAW, 1, 2, 'h111, 0);
    cycle(1, DRAW, 3, 4, 'h222, 0);
    for (int i = 0; i < 5; i++) begin
      idle(0);
      check("bp_hold_rts", out_rts, 1);
      check("bp_hold_line", dut_line(), ln(0, 0, 1, 2, 'h111));
    end
    idle(1);
    check("bp_next_line", dut_line(), ln(1, 2, 3, 4, 'h222));
    idle(1);
    check("bp_done", out_rts, 0);

    // Overflow: six pushes into four entries plus the slot; the sixth drops.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      cycle(1, DRAW, i, 0, i, 0);
      if (i == 5) check("ovf_full_before_6th", wr_full, 1);
    end
    check("ovf_set", wr_overflow, 1);
    exp_q.delete();
    got_q.delete();
    for (int i = 1; i <= 5; i++) exp_q.push_back(XW'(i));
    for (int i = 0; i < 8; i++) idle(1);
    check("ovf_line_count", got_q.size(), exp_q.size());
    while (exp_q.size() != 0 && got_q.size() != 0)
      check("ovf_x2_order", got_q.pop_front(), exp_q.pop_front());
    check("ovf_sticky", wr_overflow, 1);

    // Throughput: back-to-back DRAWs keep out_rts high.
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, DRAW, 10 + i, i, i, 0);
    check("tp_preloaded", out_rts, 1);
    pat4 = '0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      pat4 = {pat4[2:0], out_rts};
    end
    check("tp_pattern", pat4, 4'b1110);

    // A MOVE in the stream costs exactly one bubble.
    do_reset();
    cycle(1, DRAW, 1, 1, 1, 0);
    cycle(1, DRAW, 2, 2, 2, 0);
    cycle(1, MOVE, 7, 7, 0, 0);
    cycle(1, DRAW, 3, 3, 3, 0);
    cycle(1, DRAW, 4, 4, 4, 0);
    check("bub_preloaded", out_rts, 1);
    pat5 = '0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      pat5 = {pat5[3:0], out_rts};
    end
    check("bub_pattern", pat5, 5'b10110);

    // Asynchronous reset with a line in flight and three entries queued.
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, DRAW, i, i, i, 0);
    check("mid_rst_pre_rts", out_rts, 1);
    check("mid_rst_pre_count", wr_count, 3);
    #3;
    rst_ = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    cycle(1, DRAW, 5, 5, 'hABC, 1);
    idle(1);
    check("mid_rst_line", dut_line(), ln(0, 0, 5, 5, 'hABC));
    check("mid_rst_rts", out_rts, 1);

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 1023),
            $urandom_range(0, 1023), $urandom_range(0, 4095), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 12; i++) idle(1);
    check("rand_drained", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
